debug_tx_serializer: RTL and testbench

Transmit half of the debug link. On a send request from the debugger control unit, it captures a wide pipeline-state snapshot and streams it byte by byte into the UART transmitter FIFO, honouring FIFO back-pressure. When the whole frame has been handed to the FIFO, it reports completion with a level handshake. It sits between the debugger control unit (`sendSignal`/`dataSent`) and the UART TX FIFO (`wr_uart`/`w_data`/`tx_full`).

---
 rtl/debug_tx_serializer_if.sv | 33 +++
 rtl/debug_tx_serializer.sv | 102 ++++++++++
 tb/tb_debug_tx_serializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/debug_tx_serializer_if.sv
// Handshake bundle between the debugger control unit, the TX serializer and the UART TX FIFO.
// The master modport is the debugger/FIFO side. The slave modport is the serializer.
interface debug_tx_serializer_if #(
  parameter int NUM_BYTES = 220
);
  logic                   sendSignal;
  logic [8*NUM_BYTES-1:0] sendData;
  logic                   tx_full;
  logic [7:0]             w_data;
  logic                   wr_uart;
  logic                   dataSent;
  logic                   busy;

  modport master (
    output sendSignal,
    output sendData,
    output tx_full,
    input  w_data,
    input  wr_uart,
    input  dataSent,
    input  busy
  );

  modport slave (
    input  sendSignal,
    input  sendData,
    input  tx_full,
    output w_data,
    output wr_uart,
    output dataSent,
    output busy
  );
endinterface

// File: rtl/debug_tx_serializer.sv
// Debug link transmit side. It captures a snapshot and streams it LSB byte first into the UART TX FIFO.
// state | meaning
// IDLE  | waiting for sendSignal, outputs quiet
// SEND  | try to write the current byte, retry while tx_full
// GAP   | shift to the next byte and advance the count
// DONE  | frame handed over, hold dataSent until sendSignal drops
module debug_tx_serializer #(
  parameter int NUM_BYTES = 220,
  parameter int CNT_W     = 8
) (
  input logic                   clock,
  input logic                   reset,
  debug_tx_serializer_if.slave  bus
);

  if (NUM_BYTES < 1 || (2 ** CNT_W) < NUM_BYTES) begin : g_param_check
    $error("debug_tx_serializer: invalid NUM_BYTES/CNT_W");
  end

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [8*NUM_BYTES-1:0] shreg_q, shreg_d;
  logic [7:0]             w_data_q, w_data_d;
  logic                   wr_q, wr_d;
  logic                   sent_q, sent_d;

  // The whole controller moves on the falling edge, like the debugger control unit.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_data_q <= 8'h00;
      wr_q     <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_data_q <= w_data_d;
      wr_q     <= wr_d;
      sent_q   <= sent_d;
    end
  end

  // The snapshot needs no reset. It is reloaded at every frame start.
  always_ff @(negedge clock) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    w_data_d = w_data_q;
    wr_d     = 1'b0;
    sent_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sendSignal) begin
          shreg_d = bus.sendData;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.tx_full) begin
          wr_d     = 1'b1;
          w_data_d = shreg_q[7:0];
          state_d  = GAP;
        end
      end
      GAP: begin
        // The idle cycle lets tx_full catch up with the write just issued.
        shreg_d = shreg_q >> 8;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sent_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        if (bus.sendSignal) begin
          sent_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.w_data   = w_data_q;
  assign bus.wr_uart  = wr_q;
  assign bus.dataSent = sent_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Directed bench: a per-edge vector table for a 4-byte instance and a scoreboarded random back-pressure run
// on a 220-byte instance.
module tb_debug_tx_serializer;

  logic clock;
  logic rst4, rst220;

  debug_tx_serializer_if #(.NUM_BYTES(4))   bus4 ();
  debug_tx_serializer_if #(.NUM_BYTES(220)) bus220 ();

  debug_tx_serializer #(.NUM_BYTES(4), .CNT_W(8)) dut4 (
    .clock (clock),
    .reset (rst4),
    .bus   (bus4.slave)
  );

  debug_tx_serializer #(.NUM_BYTES(220), .CNT_W(8)) dut220 (
    .clock (clock),
    .reset (rst220),
    .bus   (bus220.slave)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    int          test;
    logic        rst;
    logic        ss;
    logic        full;
    logic [31:0] data;
    logic        exp_wr;
    logic [7:0]  exp_wd;
    logic        chk_wd;
    logic        exp_ds;
    logic        exp_busy;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input int t, input logic rst, input logic ss, input logic full,
                              input logic [31:0] d, input logic wr, input logic [7:0] wd,
                              input logic chk, input logic ds, input logic bz);
    vec_t v;
    v.test = t; v.rst = rst; v.ss = ss; v.full = full; v.data = d;
    v.exp_wr = wr; v.exp_wd = wd; v.chk_wd = chk; v.exp_ds = ds; v.exp_busy = bz;
    vq.push_back(v);
  endfunction

  // Unstalled frame: capture at e0, byte i at e(1+2i), dataSent at e8, held for 'hold' edges, released after.
  function automatic void add_frame(input int t, input logic [31:0] d, input logic [31:0] d_late, input int hold);
    logic [31:0] cur;
    add(t, 0, 1, 0, d, 0, 8'h00, 0, 0, 1);
    for (int e = 1; e <= 7; e++) begin
      cur = (e >= 2) ? d_late : d;
      if (e % 2 == 1) add(t, 0, 1, 0, cur, 1, d[8*((e-1)/2) +: 8], 1, 0, 1);
      else            add(t, 0, 1, 0, cur, 0, 8'h00, 0, 0, 1);
    end
    add(t, 0, 1, 0, d_late, 0, 8'h00, 0, 1, 1);
    for (int h = 0; h < hold; h++) add(t, 0, 1, 0, d_late, 0, 8'h00, 0, 1, 1);
    add(t, 0, 0, 0, d_late, 0, 8'h00, 0, 0, 0);
    add(t, 0, 0, 0, d_late, 0, 8'h00, 0, 0, 0);
  endfunction

  logic [8*220-1:0] big;
  logic             full_r, prev_wr, done;
  int               idx;

  initial begin
    rst4 = 1'b1; rst220 = 1'b1;
    bus4.sendSignal = 0; bus4.sendData = '0; bus4.tx_full = 0;
    bus220.sendSignal = 0; bus220.sendData = '0; bus220.tx_full = 0;

    // Reset state.
    add(0, 1, 0, 0, 32'h0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 1, 1, 32'h0, 0, 8'h00, 1, 0, 0);
    add(0, 0, 0, 0, 32'h0, 0, 8'h00, 0, 0, 0);
    // Basic frame, sendSignal dropped at e10.
    add_frame(1, 32'h44332211, 32'h44332211, 1);
    // tx_full high on e2..e5: e2 lands in GAP, e3..e5 each stall SEND by one cycle.
    add(2, 0, 1, 0, 32'h44332211, 0, 8'h00, 0, 0, 1);
    add(2, 0, 1, 0, 32'h44332211, 1, 8'h11, 1, 0, 1);
    for (int e = 2; e <= 5; e++) add(2, 0, 1, 1, 32'h44332211, 0, 8'h00, 0, 0, 1);
    add(2, 0, 1, 0, 32'h44332211, 1, 8'h22, 1, 0, 1);
    add(2, 0, 1, 0, 32'h44332211, 0, 8'h00, 0, 0, 1);
    add(2, 0, 1, 0, 32'h44332211, 1, 8'h33, 1, 0, 1);
    add(2, 0, 1, 0, 32'h44332211, 0, 8'h00, 0, 0, 1);
    add(2, 0, 1, 0, 32'h44332211, 1, 8'h44, 1, 0, 1);
    add(2, 0, 1, 0, 32'h44332211, 0, 8'h00, 0, 1, 1);
    add(2, 0, 0, 0, 32'h44332211, 0, 8'h00, 0, 0, 0);
    add(2, 0, 0, 0, 32'h44332211, 0, 8'h00, 0, 0, 0);
    // Reset at e4 abandons bytes 33/44.
    add(3, 0, 1, 0, 32'h44332211, 0, 8'h00, 0, 0, 1);
    add(3, 0, 1, 0, 32'h44332211, 1, 8'h11, 1, 0, 1);
    add(3, 0, 1, 0, 32'h44332211, 0, 8'h00, 0, 0, 1);
    add(3, 0, 1, 0, 32'h44332211, 1, 8'h22, 1, 0, 1);
    add(3, 1, 1, 0, 32'h44332211, 0, 8'h00, 1, 0, 0);
    for (int e = 5; e <= 10; e++) add(3, 0, 0, 0, 32'h44332211, 0, 8'h00, 0, 0, 0);
    // Snapshot changed after capture.
    add_frame(4, 32'h44332211, 32'hDEADBEEF, 1);
    // sendSignal held 20 cycles past dataSent, then a second frame.
    add_frame(5, 32'h44332211, 32'h44332211, 20);
    add_frame(5, 32'hA1B2C3D4, 32'hA1B2C3D4, 1);

    for (int r = 0; r < vq.size(); r++) begin
      rst4 = vq[r].rst;
      bus4.sendSignal = vq[r].ss;
      bus4.tx_full = vq[r].full;
      bus4.sendData = vq[r].data;
      @(negedge clock); #1;
      check($sformatf("t%0d.r%0d wr_uart", vq[r].test, r), 64'(bus4.wr_uart), 64'(vq[r].exp_wr));
      check($sformatf("t%0d.r%0d dataSent", vq[r].test, r), 64'(bus4.dataSent), 64'(vq[r].exp_ds));
      check($sformatf("t%0d.r%0d busy", vq[r].test, r), 64'(bus4.busy), 64'(vq[r].exp_busy));
      if (vq[r].chk_wd)
        check($sformatf("t%0d.r%0d w_data", vq[r].test, r), 64'(bus4.w_data), 64'(vq[r].exp_wd));
    end

    // 220-byte frame under random back-pressure.
    for (int i = 0; i < 220; i++) big[8*i +: 8] = 8'($urandom);
    rst220 = 1'b0;
    @(negedge clock); #1;
    bus220.sendSignal = 1'b1;
    bus220.sendData = big;
    @(negedge clock); #1;
    check("big capture busy", 64'(bus220.busy), 64'd1);
    idx = 0; prev_wr = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      full_r = 1'($urandom_range(0, 1));
      bus220.tx_full = full_r;
      bus220.sendData = ~big;
      @(negedge clock); #1;
      if (bus220.wr_uart) begin
        check("big write while full", 64'(full_r), 64'd0);
        check("big back-to-back wr_uart", 64'(prev_wr), 64'd0);
        if (idx < 220) check($sformatf("big byte %0d", idx), 64'(bus220.w_data), 64'(big[8*idx +: 8]));
        else check("big extra write", 64'(idx), 64'd219);
        idx++;
      end
      prev_wr = bus220.wr_uart;
      if (bus220.dataSent) done = 1;
    end
    check("big dataSent seen", 64'(done), 64'd1);
    check("big write count", 64'(idx), 64'd220);
    bus220.sendSignal = 1'b0;
    @(negedge clock); #1;
    check("big dataSent release", 64'(bus220.dataSent), 64'd0);
    check("big busy release", 64'(bus220.busy), 64'd0);
    @(negedge clock); #1;
    check("big idle wr_uart", 64'(bus220.wr_uart), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
